// File: rtl/spc700_addsub_ser.sv
// Byte-serial SPC700-style ADD/SUB (ADC/SBC semantics) with DAA/DAS decimal adjust.
// One byte per enabled cycle, LSB first; results and flags publish together with DONE.
module spc700_addsub_ser #(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [8*BYTES-1:0]   a,
  input  logic [8*BYTES-1:0]   b,
  input  logic                 ci,
  input  logic                 hi,
  output logic                 busy,
  output logic                 done,
  output logic [8*BYTES-1:0]   s,
  output logic                 co,
  output logic                 vo,
  output logic                 ho,
  output logic                 no,
  output logic                 zo
);

  localparam int W = 8 * BYTES;

  typedef enum logic [2:0] {IDLE, RUN, DADJ_HI, DADJ_LO, FIN} state_t;

  state_t         state, state_nx;
  logic [1:0]     idx;
  logic [W-1:0]   a_q, b_q, acc;
  logic [1:0]     mode_q;
  logic           hi_q, c_q, v_q, h_q;
  logic [7:0]     b_byte;
  logic [8:0]     sum_byte;
  logic           last;

  // Decimal adjust, high step: returns {carry, value}.
  function automatic logic [8:0] dec_adj_hi(input logic sub, input logic [7:0] v, input logic c);
    logic [8:0] r;
    if (!sub) r = (c || v > 8'h99) ? {1'b1, v + 8'h60} : {c, v};
    else      r = (!c || v > 8'h99) ? {1'b0, v - 8'h60} : {c, v};
    return r;
  endfunction

  // Decimal adjust, low step: the nibble test uses the original operand's low nibble.
  function automatic logic [7:0] dec_adj_lo(input logic sub, input logic [7:0] v,
                                            input logic [3:0] lo, input logic h);
    logic [7:0] r;
    if (!sub) r = (h || lo > 4'h9) ? v + 8'h06 : v;
    else      r = (!h || lo > 4'h9) ? v - 8'h06 : v;
    return r;
  endfunction

  assign b_byte   = mode_q[0] ? ~b_q[7:0] : b_q[7:0];
  assign sum_byte = {1'b0, a_q[7:0]} + {1'b0, b_byte} + {8'b0, c_q};
  assign last     = (idx == 2'(BYTES - 1));
  assign busy     = (state == RUN) || (state == DADJ_HI) || (state == DADJ_LO);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = mode[1] ? DADJ_HI : RUN;
      RUN:     if (last) state_nx = FIN;
      DADJ_HI: state_nx = DADJ_LO;
      DADJ_LO: state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control and published results: reset clears everything visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      vo    <= 1'b0;
      ho    <= 1'b0;
      no    <= 1'b0;
      zo    <= 1'b0;
    end else begin
      done <= en && (state == FIN);
      if (en) begin
        state <= state_nx;
        if (state == FIN) begin
          s  <= acc;
          co <= c_q;
          vo <= v_q;
          ho <= h_q;
          no <= mode_q[1] ? acc[7] : acc[W-1];
          zo <= (acc == '0);
        end
      end
    end
  end

  // Working registers: operands shift right one byte per RUN cycle while the
  // result assembles from the top, so intermediate bytes never reach s.
  always_ff @(posedge clk) begin
    if (en) begin
      case (state)
        IDLE: if (start) begin
          a_q    <= a;
          b_q    <= b;
          mode_q <= mode;
          c_q    <= ci;
          hi_q   <= hi;
          idx    <= 2'd0;
          acc    <= '0;
        end
        RUN: begin
          acc <= (acc >> 8) | (W'(sum_byte[7:0]) << (W - 8));
          a_q <= a_q >> 8;
          b_q <= b_q >> 8;
          c_q <= sum_byte[8];
          idx <= idx + 2'd1;
          if (last) begin
            h_q <= sum_byte[4] ^ a_q[4] ^ b_byte[4];
            v_q <= ~(a_q[7] ^ b_byte[7]) & (a_q[7] ^ sum_byte[7]);
          end
        end
        DADJ_HI: begin
          {c_q, acc[7:0]} <= dec_adj_hi(mode_q[0], a_q[7:0], c_q);
          v_q <= 1'b0;
          h_q <= 1'b0;
        end
        DADJ_LO: acc <= W'(dec_adj_lo(mode_q[0], acc[7:0], a_q[3:0], hi_q));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spc700_addsub_ser.sv
// Directed bench for spc700_addsub_ser (BYTES=2): vector table plus stall and reset sequences.
module tb_spc700_addsub_ser;

  localparam int BYTES = 2;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         ci = 1'b0, hi = 1'b0;
  logic         busy, done, co, vo, ho, no, zo;
  logic [W-1:0] s;

  spc700_addsub_ser #(.BYTES(BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .mode(mode),
    .a(a), .b(b), .ci(ci), .hi(hi),
    .busy(busy), .done(done), .s(s),
    .co(co), .vo(vo), .ho(ho), .no(no), .zo(zo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] a, b;
    logic        ci, hi;
    logic [15:0] s;
    logic [4:0]  fl;   // {co, vo, ho, no, zo}
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic h, output int lat);
    @(negedge clk);
    mode = m; a = av; b = bv; ci = c; hi = h; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; ci = ~c; hi = ~h;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;

    tbl[0]  = '{2'b00, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 5'b00100};
    tbl[1]  = '{2'b01, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 5'b00010};
    tbl[2]  = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 5'b01110};
    tbl[3]  = '{2'b10, 16'h009A, 16'h0000, 1'b0, 1'b0, 16'h0000, 5'b10001};
    tbl[4]  = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 5'b10101};
    tbl[5]  = '{2'b01, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 5'b11000};
    tbl[6]  = '{2'b00, 16'h0008, 16'h0008, 1'b1, 1'b0, 16'h0011, 5'b00000};
    tbl[7]  = '{2'b01, 16'h5555, 16'h5555, 1'b1, 1'b0, 16'h0000, 5'b10101};
    tbl[8]  = '{2'b10, 16'h0015, 16'hFFFF, 1'b0, 1'b1, 16'h001B, 5'b00000};
    tbl[9]  = '{2'b10, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'h0065, 5'b10000};
    tbl[10] = '{2'b11, 16'h0015, 16'h0000, 1'b1, 1'b0, 16'h000F, 5'b10000};
    tbl[11] = '{2'b11, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h009A, 5'b00010};
    tbl[12] = '{2'b10, 16'hAB42, 16'h1111, 1'b1, 1'b0, 16'h00A2, 5'b10010};
    tbl[13] = '{2'b11, 16'h1234, 16'h0000, 1'b1, 1'b1, 16'h0034, 5'b10000};

    // Reset state, checked before any rising edge
    #2;
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_flags", 32'({co, vo, ho, no, zo}), 32'h0);
    chk("rst_busy_done", 32'({busy, done}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].hi, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_s", i), 32'(s), 32'(tbl[i].s));
      chk($sformatf("v%0d_flags", i), 32'({co, vo, ho, no, zo}), 32'(tbl[i].fl));
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
    end

    // Second START while busy, and a 2-cycle EN stall mid-RUN
    @(negedge clk);
    mode = 2'b00; a = 16'h1234; b = 16'h0FCD; ci = 1'b0; hi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    mode = 2'b01; a = 16'hFFFF; b = 16'h0001; ci = 1'b1;
    lat = -1;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (i == 1) en = 1'b0;
      if (i == 2) chk("stall_busy", 32'(busy), 32'h1);
      if (i == 3) begin
        en = 1'b1;
        start = 1'b0;
      end
    end
    chk("stall_latency", 32'(lat), 32'd5);
    chk("stall_done_count", 32'(ndone), 32'd1);
    chk("stall_s", 32'(s), 32'h2201);
    chk("stall_flags", 32'({co, vo, ho, no, zo}), 32'b00100);

    // Reset in the middle of RUN
    @(negedge clk);
    mode = 2'b00; a = 16'h7FFF; b = 16'h0001; ci = 1'b0; hi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstrun_s", 32'(s), 32'h0);
    chk("rstrun_flags", 32'({co, vo, ho, no, zo}), 32'h0);
    chk("rstrun_busy_done", 32'({busy, done}), 32'h0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("rstrun_no_done", 32'(ndone), 32'h0);
    run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    chk("after_rst_latency", 32'(lat), 32'd3);
    chk("after_rst_s", 32'(s), 32'h8000);
    chk("after_rst_flags", 32'({co, vo, ho, no, zo}), 32'b01110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
